// File: rtl/dram_arbiter_pkg.sv
// Shared SoC bus constants: arbiter ownership encodings and default fairness bounds.
// Future bus masters and the peripheral decoder import this package too.
package dram_arbiter_pkg;

  typedef enum logic {
    ARB_OWN_CPU = 1'b0,
    ARB_OWN_DMA = 1'b1
  } arb_state_t;

  localparam int DEF_MAX_WAIT  = 4;
  localparam int DEF_MAX_BURST = 8;

endpackage

// File: rtl/dram_arbiter.sv
// CPU/DMA arbiter for the single-port data_ram; zero-latency grant from registered state.
// Losing master simply sees no grant (m0_stall for the CPU); DMA starvation bounded by MAX_WAIT, bursts by MAX_BURST.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_WAIT  = DEF_MAX_WAIT,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_stall,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_ONE  = WW'(1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

  arb_state_t    state;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] beat_cnt;
  logic          gnt0;
  logic          gnt1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (state == ARB_OWN_DMA) begin
        // An idle DMA releases the lock immediately so the CPU loses no cycle.
        gnt1 = m1_req;
        gnt0 = m0_req & ~m1_req;
      end else begin
        gnt1 = m1_req & (~m0_req | (wait_cnt == WAIT_MAX));
        gnt0 = m0_req & ~gnt1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_OWN_CPU;
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ARB_OWN_CPU: begin
          if (gnt1) begin
            wait_cnt <= '0;
            if (m1_lock && (MAX_BURST > 1)) begin
              state    <= ARB_OWN_DMA;
              beat_cnt <= BEAT_ONE;
            end
          end else if (m1_req) begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end else begin
            wait_cnt <= '0;
          end
        end
        ARB_OWN_DMA: begin
          wait_cnt <= '0;
          // Stay only while the DMA keeps a locked burst going and has beats left.
          if (m1_req && m1_lock && ((beat_cnt + BEAT_ONE) != BURST_MAX)) begin
            beat_cnt <= beat_cnt + BEAT_ONE;
          end else begin
            state    <= ARB_OWN_CPU;
            beat_cnt <= '0;
          end
        end
        default: begin
          state    <= ARB_OWN_CPU;
          wait_cnt <= '0;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  assign m0_gnt   = gnt0;
  assign m1_gnt   = gnt1;
  assign m0_stall = ~reset & m0_req & ~gnt0;
  assign m0_rdata = ram_rdata;
  assign m1_rdata = ram_rdata;

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (gnt0) begin
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
      ram_we    = m0_we;
    end else if (gnt1) begin
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
      ram_we    = m1_we;
    end
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Two-master arbiter that shares the single-port `data_ram` between the CPU data port (master 0) and a DMA/peripheral bus master (master 1). It sits between `top` and `data_ram` inside `risc_v_soc`. The CPU has default priority. A wait counter bounds DMA starvation, and a lock/beat counter bounds DMA burst length. The arbiter adds no latency: grant is decided combinationally each cycle from registered state.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `MAX_WAIT`, 4, consecutive denied m1 cycles before m1 is force-granted (≥1)
- `MAX_BURST`, 8, maximum m1 beats per locked burst, entry beat included (≥1)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `m0_req`, `m0_we`  in  1  CPU access request; write enable
- `m0_addr`  in  AW  CPU address
- `m0_wdata`  in  DW  CPU write data
- `m0_gnt`  out  1  CPU access performed this cycle
- `m0_stall`  out  1  `m0_req & ~m0_gnt`
- `m0_rdata`  out  DW  read data, valid when `m0_gnt`
- `m1_req`, `m1_we`, `m1_lock`  in  1  DMA request; write enable; burst lock
- `m1_addr`  in  AW  DMA address
- `m1_wdata`  in  DW  DMA write data
- `m1_gnt`  out  1  DMA access performed this cycle
- `m1_rdata`  out  DW  read data, valid when `m1_gnt`
- `ram_addr`  out  AW  to `data_ram.addr`
- `ram_wdata`  out  DW  to `data_ram.data_in`
- `ram_we`  out  1  to `data_ram.we`
- `ram_rdata`  in  DW  from `data_ram.data_out`

## Operation
The arbiter has two states: OWN_CPU and OWN_DMA. Registers are `state`, `wait_cnt` (width `$clog2(MAX_WAIT+1)`) and `beat_cnt` (width `$clog2(MAX_BURST+1)`).

OWN_CPU:
- If `m0_req` and `wait_cnt < MAX_WAIT`: grant m0. If `m1_req` is also high, `wait_cnt++`.
- If `m1_req` and (`!m0_req` or `wait_cnt == MAX_WAIT`): grant m1 and clear `wait_cnt`. If `m1_lock=1`, `beat_cnt` becomes 1 and the arbiter enters OWN_DMA. If `MAX_BURST==1`, it stays in OWN_CPU.
- If `m1_req=0`: clear `wait_cnt`.

OWN_DMA:
- If `m1_req`: grant m1 and `beat_cnt++`. Return to OWN_CPU after this beat if `m1_lock=0` or `beat_cnt+1 == MAX_BURST`.
- If `m1_req=0`: grant m0 if it is requesting, and return to OWN_CPU the same cycle.
- `wait_cnt` holds at 0.
- Leaving OWN_DMA clears `beat_cnt`.

Mux and data rules:
- `m0_gnt` and `m1_gnt` are never both 1.
- The granted master drives `ram_addr` and `ram_wdata`.
- `ram_we = gnt & we` of the granted master.
- With no grant, `ram_addr=0`, `ram_wdata=0`, `ram_we=0`.
- `m0_rdata = m1_rdata = ram_rdata`, unregistered.
- While `reset=1`, all grants, `m0_stall` and `ram_we` are forced to 0. `m0_stall` follows `m0_req` after reset is released.
- Masters hold `req`, `we`, `addr`, `wdata` (and `lock`) stable until granted. A master dropping `req` before grant is legal and has no side effects.

## Timing
- Reset values: state OWN_CPU, `wait_cnt=0`, `beat_cnt=0`.
- Output values during reset: `m0_gnt=0`, `m1_gnt=0`, `m0_stall=0`, `ram_we=0`, `ram_addr=0`, `ram_wdata=0`.
- Zero-cycle grant: a grant is combinational from `req` and registered state.
- Reads: data is valid in the grant cycle, since the `data_ram` read is asynchronous.
- Writes: commit on the rising edge that ends the grant cycle.
- Worst-case m1 wait under continuous m0 traffic: `MAX_WAIT` cycles.
- Worst-case m0 wait: `MAX_BURST` cycles, counting from the DMA entry beat.
- Reset asserted mid-burst: grants are 0 that cycle. On the next non-reset cycle the arbiter is in OWN_CPU with counters at 0.
- A burst ended by `MAX_BURST` with `m1_lock` still high is governed by the OWN_CPU rules next cycle, so a CPU request wins.

## Structure
- State encodings (`ARB_OWN_CPU=1'b0`, `ARB_OWN_DMA=1'b1`) and default `MAX_WAIT`/`MAX_BURST` go in the shared SoC bus constants package/header. Future bus masters and the peripheral decoder use the same package.
- No sub-module: one FSM process plus the combinational grant/mux logic.
- `risc_v_soc` instantiates `dram_arbiter` between `top` and `data_ram`. `top` ram signals map to m0, with `m0_req = ram_we | cpu load` as driven by `top`.

## Test plan
1. **Reset:** both reqs high with `reset=1` → `m0_gnt=0`, `m1_gnt=0`, `ram_we=0`. After release, an m0-only request → `m0_gnt=1` the same cycle.
2. **CPU-only write:** `m0_req=1`, `m0_we=1`, addr `0x10`, data `0xDEADBEEF` → `ram_we=1`, `ram_addr=0x10` the same cycle. A read of `0x10` next cycle → `m0_rdata=0xDEADBEEF`.
3. **Continuous contention, lock=0, `MAX_WAIT=4`** → m0 granted cycles 0–3, m1 granted cycle 4 with `m0_stall=1`, m0 cycles 5–8, m1 cycle 9.
4. **Locked burst, `MAX_BURST=8`:** m1 requests 12 beats with lock=1 while m0 is idle; m0 requests from cycle 2 → m1 granted cycles 0–7, m0 granted cycle 8, m1 force-granted no later than cycle 12.
5. **Lock drop:** `m1_lock=0` on beat 3 with m0 pending → beat 3 goes to m1, cycle 4 goes to m0. `beat_cnt` reads 0 after the transition.
6. **Reset mid-burst (beat 5)** → no grant in the reset cycle. The next cycle, with both requesting, m0 is granted and `wait_cnt` starts from 0.
